// File: rtl/fixed_unroller_pkg.sv
// Shared helpers for the fixed-point unroller: chunk ratio, counter width, config check.
// Latency: n/a (elaboration-time functions and types only).
// Backpressure: n/a.
package fixed_unroller_pkg;

  // Default element width used by code that needs a concrete element type.
  localparam int ELEM_WIDTH = 8;

  typedef logic [ELEM_WIDTH-1:0] elem_t;

  // Input beats per output vector; guards against a zero IN_NUM so a bad
  // configuration reaches the config check instead of a divide-by-zero.
  function automatic int calc_ratio(input int in_num, input int out_num);
    return (in_num > 0) ? (out_num / in_num) : 1;
  endfunction

  // Chunk counter width, never narrower than one bit (RATIO==1 keeps cnt at 0).
  function automatic int calc_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // OUT_NUM must be a whole, non-zero number of IN_NUM chunks.
  function automatic bit cfg_ok(input int in_num, input int out_num);
    return (in_num > 0) && (out_num >= in_num) && ((out_num % in_num) == 0);
  endfunction

endpackage

// File: rtl/unroller_collect.sv
// Chunk counter plus collect buffer; merges the incoming chunk at slot cnt.
// Latency: merge_o is combinational; buffer/counter update on the accepting edge.
// Backpressure: none here; the parent decides when a beat is accepted.
module unroller_collect
  import fixed_unroller_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 1,
  parameter int OUT_NUM    = 4,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_acc_i,
  input  logic                  wrap_i,
  input  logic [DATA_WIDTH-1:0] chunk_i [IN_NUM],
  output logic [CNT_W-1:0]      cnt_o,
  output logic [DATA_WIDTH-1:0] merge_o [OUT_NUM]
);

  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [OUT_NUM];
  logic [DATA_WIDTH-1:0] buf_d [OUT_NUM];
  logic [DATA_WIDTH-1:0] merge [OUT_NUM];

  // Buffer as it would look with the current chunk written into slot cnt.
  always_comb begin
    for (int i = 0; i < OUT_NUM; i++) begin
      merge[i] = buf_q[i];
      if ((i / IN_NUM) == int'(cnt_q)) begin
        merge[i] = chunk_i[i % IN_NUM];
      end
    end
  end

  // Next state: commit the merged buffer and step/wrap the slot counter.
  // The buffer is deliberately not cleared on wrap; stale upper slots are
  // overwritten before they can be part of another completed vector.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < OUT_NUM; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (beat_acc_i) begin
      for (int i = 0; i < OUT_NUM; i++) begin
        buf_d[i] = merge[i];
      end
      cnt_d = wrap_i ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int i = 0; i < OUT_NUM; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < OUT_NUM; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign cnt_o   = cnt_q;
  assign merge_o = merge;

endmodule

// File: rtl/fixed_unroller.sv
// Gathers RATIO narrow IN_NUM-element beats into one OUT_NUM-element vector.
// Latency: 1 cycle from the completing input beat to data_out_0_valid.
// Backpressure: only the completing beat stalls, while a full output is undrained.
//   Optional FIXED_UNROLLER_FLUSH_EN adds data_in_0_last to close a short vector.
module fixed_unroller
  import fixed_unroller_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 1,
  parameter int OUT_NUM    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in_0 [IN_NUM],
  input  logic                  data_in_0_valid,
  output logic                  data_in_0_ready,
  output logic [DATA_WIDTH-1:0] data_out_0 [OUT_NUM],
  output logic                  data_out_0_valid,
  input  logic                  data_out_0_ready
`ifdef FIXED_UNROLLER_FLUSH_EN
  ,
  input  logic                  data_in_0_last
`endif
);

  localparam int RATIO = calc_ratio(IN_NUM, OUT_NUM);
  localparam int CNT_W = calc_cnt_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if (!cfg_ok(IN_NUM, OUT_NUM)) begin : g_cfg_err
    $error("fixed_unroller: OUT_NUM must be a non-zero multiple of IN_NUM");
  end

  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] merge    [OUT_NUM];
  logic [DATA_WIDTH-1:0] load_vec [OUT_NUM];
  logic [DATA_WIDTH-1:0] out_q    [OUT_NUM];
  logic [DATA_WIDTH-1:0] out_d    [OUT_NUM];
  logic                  out_vld_q;
  logic                  out_vld_d;
  logic                  last_beat;
  logic                  at_end;
  logic                  accept;
  logic                  complete;

`ifdef FIXED_UNROLLER_FLUSH_EN
  assign last_beat = data_in_0_last;
`else
  assign last_beat = 1'b0;
`endif

  // A beat closes the vector at the final slot, or early when flagged last.
  assign at_end          = (cnt == LAST_CNT) || last_beat;
  assign data_in_0_ready = !(at_end && out_vld_q && !data_out_0_ready);
  assign accept          = data_in_0_valid && data_in_0_ready;
  assign complete        = accept && at_end;

  unroller_collect #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_NUM     (IN_NUM),
    .OUT_NUM    (OUT_NUM),
    .CNT_W      (CNT_W)
  ) u_collect (
    .clk        (clk),
    .rst        (rst),
    .beat_acc_i (accept),
    .wrap_i     (at_end),
    .chunk_i    (data_in_0),
    .cnt_o      (cnt),
    .merge_o    (merge)
  );

  // Vector presented on completion; a flushed vector zeroes slots above cnt.
  always_comb begin
    for (int i = 0; i < OUT_NUM; i++) begin
      load_vec[i] = merge[i];
      if (last_beat && ((i / IN_NUM) > int'(cnt))) begin
        load_vec[i] = '0;
      end
    end
  end

  // Output slot: load on completion (even while draining), else clear on accept.
  always_comb begin
    out_vld_d = out_vld_q;
    for (int i = 0; i < OUT_NUM; i++) begin
      out_d[i] = out_q[i];
    end
    if (complete) begin
      out_vld_d = 1'b1;
      for (int i = 0; i < OUT_NUM; i++) begin
        out_d[i] = load_vec[i];
      end
    end else if (data_out_0_ready) begin
      out_vld_d = 1'b0;
    end
  end

  // Output register with synchronous active-low reset; drops any held vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld_q <= 1'b0;
      for (int i = 0; i < OUT_NUM; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      out_vld_q <= out_vld_d;
      for (int i = 0; i < OUT_NUM; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  assign data_out_0       = out_q;
  assign data_out_0_valid = out_vld_q;

endmodule

// File: tb/tb_fixed_unroller.sv
// Self-checking bench: per-cycle handshake table, vector scoreboard, corner sequences.
// Latency: n/a.
// Backpressure: driven from the table and hand-written sequences.
module tb_fixed_unroller;
  import fixed_unroller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: IN_NUM=1, OUT_NUM=4
  elem_t a_in  [1];
  logic  a_vld = 1'b0;
  logic  a_irdy;
  elem_t a_out [4];
  logic  a_ovld;
  logic  a_ordy = 1'b1;
  logic  a_last = 1'b0;
  logic [31:0] a_pk;
  assign a_pk = {a_out[3], a_out[2], a_out[1], a_out[0]};

  // DUT B: IN_NUM=2, OUT_NUM=2 (RATIO 1)
  elem_t b_in  [2];
  logic  b_vld = 1'b0;
  logic  b_irdy;
  elem_t b_out [2];
  logic  b_ovld;
  logic  b_ordy = 1'b1;
  logic [15:0] b_pk;
  assign b_pk = {b_out[1], b_out[0]};

  fixed_unroller #(.DATA_WIDTH(8), .IN_NUM(1), .OUT_NUM(4)) u_a (
    .clk(clk), .rst(rst),
    .data_in_0(a_in), .data_in_0_valid(a_vld), .data_in_0_ready(a_irdy),
    .data_out_0(a_out), .data_out_0_valid(a_ovld), .data_out_0_ready(a_ordy)
`ifdef FIXED_UNROLLER_FLUSH_EN
    , .data_in_0_last(a_last)
`endif
  );

  fixed_unroller #(.DATA_WIDTH(8), .IN_NUM(2), .OUT_NUM(2)) u_b (
    .clk(clk), .rst(rst),
    .data_in_0(b_in), .data_in_0_valid(b_vld), .data_in_0_ready(b_irdy),
    .data_out_0(b_out), .data_out_0_valid(b_ovld), .data_out_0_ready(b_ordy)
`ifdef FIXED_UNROLLER_FLUSH_EN
    , .data_in_0_last(1'b0)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: simple 4-slot gather model for DUT A, compared on output handshake.
  logic [31:0] exp_q [$];
  int          m_cnt = 0;
  logic [31:0] m_buf = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (a_ovld && a_ordy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected no vector", a_pk);
        end else begin
          check("sb_vector", a_pk, exp_q.pop_front());
        end
      end
      if (prev_stall) check("hold_stable", a_pk, prev_dat);
      prev_stall = a_ovld && !a_ordy;
      prev_dat   = a_pk;
      if (a_vld && a_irdy) begin
        m_buf[8*m_cnt +: 8] = a_in[0];
        if (m_cnt == 3 || a_last) begin
          logic [31:0] v;
          v = m_buf;
          for (int j = m_cnt + 1; j < 4; j++) v[8*j +: 8] = 8'h00;
          exp_q.push_back(v);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Per-cycle handshake table for DUT A.
  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       ordy;
    logic       exp_irdy;
    logic       exp_ovld;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input logic vld, input logic [7:0] dat, input logic ordy,
                     input logic exp_irdy, input logic exp_ovld);
    vec_t r;
    r.vld = vld; r.dat = dat; r.ordy = ordy; r.exp_irdy = exp_irdy; r.exp_ovld = exp_ovld;
    tbl.push_back(r);
  endtask

  task automatic send_a(input logic [7:0] dat, input logic last, input string nm);
    a_vld = 1'b1; a_in[0] = dat; a_last = last;
    @(negedge clk);
    check(nm, a_irdy, 1'b1);
    @(posedge clk); #1;
    a_vld = 1'b0; a_last = 1'b0;
  endtask

  initial begin
    a_in[0] = '0; b_in[0] = '0; b_in[1] = '0;
    // single vector, exactly one valid cycle
    add(1, 8'h11, 1, 1, 0); add(1, 8'h22, 1, 1, 0); add(1, 8'h33, 1, 1, 0);
    add(1, 8'h44, 1, 1, 0); add(0, 8'h00, 1, 1, 1); add(0, 8'h00, 1, 1, 0);
    // 8 back-to-back beats, vectors 4 cycles apart, ready never drops
    add(1, 8'h01, 1, 1, 0); add(1, 8'h02, 1, 1, 0); add(1, 8'h03, 1, 1, 0);
    add(1, 8'h04, 1, 1, 0); add(1, 8'h05, 1, 1, 1); add(1, 8'h06, 1, 1, 0);
    add(1, 8'h07, 1, 1, 0); add(1, 8'h08, 1, 1, 0); add(0, 8'h00, 1, 1, 1);
    add(0, 8'h00, 1, 1, 0);
    // backpressure: completion beat stalls, then load-while-drain with no bubble
    add(1, 8'h21, 1, 1, 0); add(1, 8'h22, 1, 1, 0); add(1, 8'h23, 1, 1, 0);
    add(1, 8'h24, 1, 1, 0); add(1, 8'h31, 0, 1, 1); add(1, 8'h32, 0, 1, 1);
    add(1, 8'h33, 0, 1, 1); add(1, 8'h34, 0, 0, 1); add(1, 8'h34, 0, 0, 1);
    add(1, 8'h34, 1, 1, 1); add(0, 8'h00, 0, 1, 1); add(0, 8'h00, 1, 1, 1);
    add(0, 8'h00, 1, 1, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_a_ovld", a_ovld, 1'b0);
    check("rst_a_irdy", a_irdy, 1'b1);
    check("rst_a_dat",  a_pk, 32'h0);
    check("rst_b_ovld", b_ovld, 1'b0);
    check("rst_b_irdy", b_irdy, 1'b1);
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      a_vld = tbl[k].vld; a_in[0] = tbl[k].dat; a_ordy = tbl[k].ordy;
      @(negedge clk);
      check($sformatf("tbl%0d_in_rdy", k), a_irdy, tbl[k].exp_irdy);
      check($sformatf("tbl%0d_out_vld", k), a_ovld, tbl[k].exp_ovld);
      @(posedge clk); #1;
    end
    a_vld = 1'b0;

    // reset discards a held vector and a partial one
    a_ordy = 1'b0;
    send_a(8'h51, 1'b0, "mid_rdy0"); send_a(8'h52, 1'b0, "mid_rdy1");
    send_a(8'h53, 1'b0, "mid_rdy2"); send_a(8'h54, 1'b0, "mid_rdy3");
    send_a(8'h55, 1'b0, "mid_rdy_full0"); send_a(8'h66, 1'b0, "mid_rdy_full1");
    @(negedge clk);
    check("held_before_rst", a_ovld, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_ovld", a_ovld, 1'b0);
    check("post_rst_irdy", a_irdy, 1'b1);
    check("post_rst_dat",  a_pk, 32'h0);
    @(posedge clk); #1;
    a_ordy = 1'b1;
    send_a(8'hA0, 1'b0, "ra0"); send_a(8'hA1, 1'b0, "ra1");
    send_a(8'hA2, 1'b0, "ra2"); send_a(8'hA3, 1'b0, "ra3");
    @(negedge clk);
    check("rst_seq_ovld", a_ovld, 1'b1);
    check("rst_seq_dat",  a_pk, 32'hA3A2A1A0);
    @(posedge clk); #1;

    // RATIO==1 register slice
    b_ordy = 1'b0; b_vld = 1'b1; b_in[0] = 8'h7F; b_in[1] = 8'h80;
    @(negedge clk);
    check("b_lat_ovld0", b_ovld, 1'b0);
    @(posedge clk); #1 b_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("b_hold%0d_ovld", c), b_ovld, 1'b1);
      check($sformatf("b_hold%0d_dat", c), b_pk, 16'h807F);
      check($sformatf("b_hold%0d_irdy", c), b_irdy, 1'b0);
      @(posedge clk); #1;
    end
    b_ordy = 1'b1;
    @(negedge clk);
    check("b_drain_ovld", b_ovld, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_clear_ovld", b_ovld, 1'b0);
    @(posedge clk); #1;
    b_vld = 1'b1; b_in[0] = 8'h01; b_in[1] = 8'h02;
    @(posedge clk); #1;
    b_in[0] = 8'h03; b_in[1] = 8'h04;
    @(negedge clk);
    check("b_tp0_dat",  b_pk, 16'h0201);
    check("b_tp0_irdy", b_irdy, 1'b1);
    @(posedge clk); #1 b_vld = 1'b0;
    @(negedge clk);
    check("b_tp1_ovld", b_ovld, 1'b1);
    check("b_tp1_dat",  b_pk, 16'h0403);
    @(posedge clk); #1;

`ifdef FIXED_UNROLLER_FLUSH_EN
    // early close with zero padding, next beat restarts at element 0
    send_a(8'h05, 1'b0, "fl0"); send_a(8'h06, 1'b1, "fl1");
    @(negedge clk);
    check("flush_ovld", a_ovld, 1'b1);
    check("flush_dat",  a_pk, 32'h00000605);
    @(posedge clk); #1;
    send_a(8'h09, 1'b0, "fl2"); send_a(8'h0A, 1'b0, "fl3");
    send_a(8'h0B, 1'b0, "fl4"); send_a(8'h0C, 1'b0, "fl5");
    @(negedge clk);
    check("flush_next_dat", a_pk, 32'h0C0B0A09);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
